// File: rtl/peripheral_bus_device_pkg.sv
// rtl/peripheral_bus_device_pkg.sv - shared register map, TCON bit indices and widths
// Purpose: constants shared by the bus device top and its timer sub-module.
package peripheral_bus_device_pkg;

  localparam int DATA_W = 32;
  localparam int TCON_W = 3;
  localparam int LED_W  = 8;
  localparam int DIGI_W = 12;

  // Word offsets from BASE_ADDR (only the low five bits are decoded past the span check)
  localparam logic [4:0] OFF_TH      = 5'h00;
  localparam logic [4:0] OFF_TL      = 5'h04;
  localparam logic [4:0] OFF_TCON    = 5'h08;
  localparam logic [4:0] OFF_LED     = 5'h0C;
  localparam logic [4:0] OFF_DIGI    = 5'h10;
  localparam logic [4:0] OFF_SYSTICK = 5'h14;
  localparam logic [DATA_W-1:0] REG_SPAN = 32'h18;

  // TCON bit indices
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

endpackage

// File: rtl/peripheral_bus_device_if.sv
// rtl/peripheral_bus_device_if.sv - CPU memory bus bundle between CPU and device
// Purpose: groups the CPU-side strobes, address/data and device response.
// Ports: master = CPU side (drives strobes), slave = device side (drives read data/hit).
interface peripheral_bus_device_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] MemBus_Address;
  logic [31:0] MemBus_Write_Data;
  logic [31:0] Device_Read_Data;
  logic        Device_Hit;

  modport master (
    output MemRead, MemWrite, MemBus_Address, MemBus_Write_Data,
    input  Device_Read_Data, Device_Hit
  );

  modport slave (
    input  MemRead, MemWrite, MemBus_Address, MemBus_Write_Data,
    output Device_Read_Data, Device_Hit
  );
endinterface

// File: rtl/peripheral_bus_device_timer.sv
// rtl/peripheral_bus_device_timer.sv - TH/TL/TCON reload timer with interrupt status
// Purpose: TL counts up while EN, reloads from TH on all-ones and latches IS when IE.
// Ports: clk, reset (sync active-low), wr_th/wr_tl/wr_tcon write enables,
//        wdata write data, th/tl/tcon register values.
module peripheral_timer
  import peripheral_bus_device_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_th,
  input  logic              wr_tl,
  input  logic              wr_tcon,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] th,
  output logic [DATA_W-1:0] tl,
  output logic [TCON_W-1:0] tcon
);

  // Wrap is judged on pre-edge TL/EN, so it still raises IS even if TL is
  // overwritten by the bus in the same cycle.
  logic wrap;
  assign wrap = tcon[TCON_EN] && (tl == {DATA_W{1'b1}});

  always_ff @(posedge clk) begin
    if (!reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
    end else begin
      if (wr_th) th <= wdata;

      if (wr_tl)                tl <= wdata;
      else if (wrap)            tl <= th;
      else if (tcon[TCON_EN])   tl <= tl + 32'd1;

      if (wr_tcon) tcon <= wdata[TCON_W-1:0];
      // Placed after the bus write so a same-cycle clear cannot lose the interrupt
      if (wrap && tcon[TCON_IE]) tcon[TCON_IS] <= 1'b1;
    end
  end

endmodule

// File: rtl/peripheral_bus_device.sv
// rtl/peripheral_bus_device.sv - memory-mapped timer, LED, digit and systick device
// Purpose: decodes six word registers at BASE_ADDR, zero-latency reads, clocked writes.
// Ports: clk, reset (sync active-low), bus (CPU bus, slave side),
//        irq (TCON.IS), leds (LED[7:0]), digits (DIGI[11:0]).
module peripheral_bus_device
  import peripheral_bus_device_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  peripheral_bus_device_if.slave       bus,
  output logic                         irq,
  output logic [LED_W-1:0]             leds,
  output logic [DIGI_W-1:0]            digits
);

  logic [DATA_W-1:0] offset;
  logic [4:0]        reg_off;
  logic              hit;
  logic              wr;
  logic [DATA_W-1:0] th, tl;
  logic [TCON_W-1:0] tcon;
  logic [LED_W-1:0]  led_q;
  logic [DIGI_W-1:0] digi_q;
  logic [DATA_W-1:0] systick;
  logic [DATA_W-1:0] rdata;

  // Addresses below BASE_ADDR wrap to huge offsets and fail the span check
  assign offset  = bus.MemBus_Address - BASE_ADDR;
  assign reg_off = offset[4:0];
  assign hit     = (offset < REG_SPAN) && (bus.MemBus_Address[1:0] == 2'b00);
  assign wr      = bus.MemWrite && hit;

  peripheral_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .wr_th   (wr && (reg_off == OFF_TH)),
    .wr_tl   (wr && (reg_off == OFF_TL)),
    .wr_tcon (wr && (reg_off == OFF_TCON)),
    .wdata   (bus.MemBus_Write_Data),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      led_q   <= '0;
      digi_q  <= '0;
      systick <= '0;
    end else begin
      systick <= systick + 32'd1;
      if (wr && (reg_off == OFF_LED))  led_q  <= bus.MemBus_Write_Data[LED_W-1:0];
      if (wr && (reg_off == OFF_DIGI)) digi_q <= bus.MemBus_Write_Data[DIGI_W-1:0];
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.MemRead && hit) begin
      case (reg_off)
        OFF_TH:      rdata = th;
        OFF_TL:      rdata = tl;
        OFF_TCON:    rdata = {{(DATA_W-TCON_W){1'b0}}, tcon};
        OFF_LED:     rdata = {{(DATA_W-LED_W){1'b0}}, led_q};
        OFF_DIGI:    rdata = {{(DATA_W-DIGI_W){1'b0}}, digi_q};
        OFF_SYSTICK: rdata = systick;
        default:     rdata = '0;
      endcase
    end
  end

  assign bus.Device_Read_Data = rdata;
  assign bus.Device_Hit       = hit;
  assign irq                  = tcon[TCON_IS];
  assign leds                 = led_q;
  assign digits               = digi_q;

endmodule

// File: tb/tb_peripheral_bus_device.sv
// tb/tb_peripheral_bus_device.sv - directed scoreboard bench for peripheral_bus_device
module tb_peripheral_bus_device;

  localparam logic [31:0] B = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        irq;
  logic [7:0]  leds;
  logic [11:0] digits;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] exp_q[$];
  logic        hit_q[$];

  peripheral_bus_device_if bus ();

  peripheral_bus_device #(.BASE_ADDR(B)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .irq    (irq),
    .leds   (leds),
    .digits (digits)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Read in the next cycle; expectations go through the scoreboard queues
  task automatic rd(input logic [31:0] a, input logic [31:0] e, input logic h, input string tag);
    @(negedge clk);
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b1;
    bus.MemBus_Address = a;
    exp_q.push_back(e);
    hit_q.push_back(h);
    #1;
    chk(bus.Device_Read_Data, exp_q.pop_front(), {tag, "_data"});
    chk(32'(bus.Device_Hit), 32'(hit_q.pop_front()), {tag, "_hit"});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b1;
    bus.MemBus_Address    = a;
    bus.MemBus_Write_Data = d;
    @(posedge clk);
    #1;
    bus.MemWrite = 1'b0;
  endtask

  // Reset with a concurrent LED write that must lose
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b1;
    bus.MemBus_Address    = B + 32'h0C;
    bus.MemBus_Write_Data = 32'hFF;
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.MemWrite = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    bus.MemRead = 1'b0;
    bus.MemWrite = 1'b0;
    bus.MemBus_Address = '0;
    bus.MemBus_Write_Data = '0;
    apply_reset();

    // Reset state and systick
    rd(B + 32'h14, 32'd0, 1'b1, "systick_c0");
    rd(B + 32'h14, 32'd1, 1'b1, "systick_c1");
    wr(B + 32'h14, 32'hDEAD_BEEF);
    rd(B + 32'h14, 32'd3, 1'b1, "systick_wr_ignored");
    rd(B + 32'h00, 32'd0, 1'b1, "rst_th");
    rd(B + 32'h04, 32'd0, 1'b1, "rst_tl");
    rd(B + 32'h08, 32'd0, 1'b1, "rst_tcon");
    rd(B + 32'h0C, 32'd0, 1'b1, "rst_led");
    rd(B + 32'h10, 32'd0, 1'b1, "rst_digi");
    chk(32'(irq), 32'd0, "rst_irq");
    chk(32'(leds), 32'd0, "rst_leds");
    chk(32'(digits), 32'd0, "rst_digits");
    @(negedge clk);
    bus.MemRead = 1'b0;
    bus.MemBus_Address = B + 32'h14;
    #1;
    chk(bus.Device_Read_Data, 32'd0, "no_strobe_zero");

    // Reload with interrupt
    wr(B + 32'h00, 32'hFFFF_FFF0);
    wr(B + 32'h04, 32'hFFFF_FFFE);
    wr(B + 32'h08, 32'd3);
    rd(B + 32'h04, 32'hFFFF_FFFE, 1'b1, "ie_tl0");
    chk(32'(irq), 32'd0, "ie_irq_before");
    rd(B + 32'h04, 32'hFFFF_FFFF, 1'b1, "ie_tl1");
    rd(B + 32'h04, 32'hFFFF_FFF0, 1'b1, "ie_reload");
    chk(32'(irq), 32'd1, "ie_irq_after");
    rd(B + 32'h08, 32'd7, 1'b1, "ie_tcon");

    // Bus write to TL beats the count
    wr(B + 32'h04, 32'h100);
    rd(B + 32'h04, 32'h100, 1'b1, "tl_wr_prio");
    rd(B + 32'h04, 32'h101, 1'b1, "tl_count_on");

    // Reload without interrupt
    wr(B + 32'h08, 32'd0);
    rd(B + 32'h08, 32'd0, 1'b1, "tcon_cleared");
    wr(B + 32'h00, 32'h1234_5678);
    wr(B + 32'h04, 32'hFFFF_FFFE);
    wr(B + 32'h08, 32'd1);
    rd(B + 32'h04, 32'hFFFF_FFFE, 1'b1, "noie_tl0");
    rd(B + 32'h04, 32'hFFFF_FFFF, 1'b1, "noie_tl1");
    rd(B + 32'h04, 32'h1234_5678, 1'b1, "noie_reload");
    chk(32'(irq), 32'd0, "noie_irq");
    rd(B + 32'h04, 32'h1234_5679, 1'b1, "noie_next");

    // TCON write clearing IS in the wrap cycle
    wr(B + 32'h08, 32'd0);
    wr(B + 32'h04, 32'hFFFF_FFFE);
    wr(B + 32'h08, 32'd3);
    rd(B + 32'h04, 32'hFFFF_FFFE, 1'b1, "race_tl0");
    wr(B + 32'h08, 32'd3);
    chk(32'(irq), 32'd1, "race_irq_kept");
    rd(B + 32'h04, 32'h1234_5678, 1'b1, "race_reload");
    rd(B + 32'h08, 32'd7, 1'b1, "race_tcon");

    // Hold when disabled
    wr(B + 32'h08, 32'd0);
    rd(B + 32'h04, 32'h1234_567B, 1'b1, "hold_a");
    rd(B + 32'h04, 32'h1234_567B, 1'b1, "hold_b");

    // Non-hits: out of range and unaligned
    rd(B + 32'h18, 32'd0, 1'b0, "miss_18");
    rd(B + 32'h02, 32'd0, 1'b0, "miss_02");
    rd(B - 32'h04, 32'd0, 1'b0, "miss_below");
    wr(B + 32'h18, 32'hAAAA_AAAA);
    wr(B + 32'h02, 32'hBBBB_BBBB);
    wr(B + 32'h0D, 32'hCCCC_CCCC);
    rd(B + 32'h00, 32'h1234_5678, 1'b1, "miss_th_kept");
    rd(B + 32'h0C, 32'd0, 1'b1, "miss_led_kept");
    rd(B + 32'h04, 32'h1234_567B, 1'b1, "miss_tl_kept");
    rd(B + 32'h08, 32'd0, 1'b1, "miss_tcon_kept");

    // LED/DIGI then reset mid-count
    wr(B + 32'h0C, 32'h1A5);
    wr(B + 32'h10, 32'hF3C0);
    chk(32'(leds), 32'hA5, "leds_val");
    chk(32'(digits), 32'h3C0, "digits_val");
    rd(B + 32'h0C, 32'hA5, 1'b1, "led_rd");
    rd(B + 32'h10, 32'h3C0, 1'b1, "digi_rd");
    wr(B + 32'h08, 32'd7);
    chk(32'(irq), 32'd1, "irq_sw_set");
    apply_reset();
    chk(32'(irq), 32'd0, "post_rst_irq");
    chk(32'(leds), 32'd0, "post_rst_leds");
    chk(32'(digits), 32'd0, "post_rst_digits");
    rd(B + 32'h04, 32'd0, 1'b1, "post_rst_tl");
    rd(B + 32'h00, 32'd0, 1'b1, "post_rst_th");
    rd(B + 32'h08, 32'd0, 1'b1, "post_rst_tcon");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/peripheral_bus_device.md
PERIPHERAL_BUS_DEVICE -- requirements
Module: peripheral_bus_device

Interface
REQ-001 SHALL have parameter: BASE_ADDR, 32'h4000_0000, byte address of the first device register.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port: MemRead  input  1  bus read strobe from CPU.
REQ-005 SHALL have port: MemWrite  input  1  bus write strobe from CPU.
REQ-006 SHALL have port: MemBus_Address  input  32  byte address from CPU.
REQ-007 SHALL have port: MemBus_Write_Data  input  32  write data from CPU.
REQ-008 SHALL have port: Device_Read_Data  output  32  read data to CPU.
REQ-009 SHALL have port: Device_Hit  output  1  address decodes to this device; CPU selects Device_Read_Data over data memory.
REQ-010 SHALL have port: irq  output  1  timer interrupt request, equals TCON[2].
REQ-011 SHALL have port: leds  output  8  LED register bits [7:0].
REQ-012 SHALL have port: digits  output  12  digit register bits [11:0] (anode[11:8], segments[7:0]).

Function
REQ-013 SHALL map word registers at BASE_ADDR offsets: 0x00 TH, 0x04 TL, 0x08 TCON, 0x0C LED, 0x10 DIGI, 0x14 SYSTICK.
REQ-014 SHALL assert Device_Hit combinationally iff address is one of the six offsets and address[1:0]==2'b00; other addresses (incl. unaligned) are not hits.
REQ-015 SHALL drive Device_Read_Data combinationally, zero-latency, with the selected register value when MemRead && Device_Hit, else 32'h0.
REQ-016 SHALL read unused register bits as 0 (TCON[31:3], LED[31:8], DIGI[31:12]).
REQ-017 SHALL perform writes at posedge clk when MemWrite && Device_Hit; writes to SYSTICK and non-hits SHALL be ignored.
REQ-018 SHALL update SYSTICK = SYSTICK+1 every cycle out of reset, wrapping 32'hFFFF_FFFF -> 0.
REQ-019 SHALL, when TCON[0]=1, increment TL each cycle; when TL==32'hFFFF_FFFF, load TL<=TH instead and set TCON[2] if TCON[1]=1.
REQ-020 SHALL hold TL when TCON[0]=0.
REQ-021 SHALL give a bus write to TL priority over the increment/reload in the same cycle.
REQ-022 SHALL give hardware setting of TCON[2] priority over a same-cycle bus write clearing it (no lost interrupt); other TCON bits take the written value.
REQ-023 SHALL return pre-edge values on reads coinciding with a write or count (read is combinational).
REQ-024 SHALL ignore MemRead for side effects (reads never modify state).

Reset
REQ-025 SHALL, when reset==0 at posedge clk, clear TH, TL, TCON, LED, DIGI, SYSTICK to 0; irq, leds, digits SHALL be 0 the following cycle.
REQ-026 SHALL let reset override any same-cycle bus write or count, including mid-count.

Structure
REQ-027 SHALL place register offsets, TCON bit indices (EN=0, IE=1, IS=2) and register widths in a shared package.
REQ-028 SHALL implement TH/TL/TCON and reload/interrupt logic in one sub-module peripheral_timer; decode, LED, DIGI, SYSTICK stay in the top.

Verification
REQ-029 SHALL cover: write TH=32'hFFFF_FFF0, TL=32'hFFFF_FFFE, TCON=3 -> TL reads FFFF_FFFF next cycle, then FFFF_FFF0, irq=1 from that cycle.
REQ-030 SHALL cover: TCON=1 (IE=0), TL wraps -> TL reloads from TH, irq stays 0.
REQ-031 SHALL cover: write TCON=3 (clears IS) in the exact cycle TL==FFFF_FFFF with IE=1 -> irq=1 after edge.
REQ-032 SHALL cover: read 0x4000_0014 on two consecutive cycles after reset -> values differ by 1; write to it -> no effect.
REQ-033 SHALL cover: read/write 0x4000_0018 and 0x4000_0002 -> Device_Hit=0, Device_Read_Data=0, no register changes.
REQ-034 SHALL cover: LED=32'h1A5, DIGI=32'hF3C0 written, then reset=0 one cycle -> leds=0xA5 before reset, all outputs 0 after.
